// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants used by the receive controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int MID_START = 7;
  localparam int BIT_TICKS = 16;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bundle: serial pin and oversampling tick in, word/status out.
interface uart_rx_ctrl_if #(
  parameter int DBIT = 8
);

  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  // master = pin/timer side, slave = the receive controller
  modport master (
    output rx,
    output s_tick,
    input  rx_dout,
    input  rx_done_tick,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  s_tick,
    output rx_dout,
    output rx_done_tick,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to RESET_VAL
// so an idle-high line reads as idle straight out of reset.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x-oversampled start detection, mid-bit data
// sampling (LSB first, no parity) and stop-bit check.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_e       state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            arm_q, arm_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.rx),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      arm_q   <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      arm_q   <= arm_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // arm must see the line high first, so a held-low break cannot retrigger
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    arm_d   = arm_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s) arm_d = 1'b1;
        if (arm_q && !rx_s) begin
          state_d = START;
          s_d     = '0;
          arm_d   = 1'b0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_q == 5'(MID_START)) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
              arm_d   = 1'b0;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_q == 5'(BIT_TICKS - 1)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            s_d     = '0;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            arm_d   = 1'b0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_dout      = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: clean, back-to-back, glitch, stalled tick,
// framing error, mid-frame reset and break frames with hand-computed results.
module tb_uart_rx_ctrl;

  localparam int TICK_DIV = 4;

  logic clk;
  logic reset_n;

  uart_rx_ctrl_if #(.DBIT(8)) bus ();

  uart_rx_ctrl #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int cycleNum      = 0;
  int tickCnt       = 0;
  int bitClks       = 16 * TICK_DIV;
  int startCycle    = 0;
  int lastDoneCycle = 0;
  int doneCount     = 0;
  int runLen        = 0;
  int maxRun        = 0;
  int baseCount     = 0;
  logic busyAtDone  = 1'b1;
  logic tickStuck   = 1'b0;
  logic tickEnable  = 1'b1;
  logic [7:0] b2bVec [3] = '{8'h00, 8'hFF, 8'h55};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Oversampling tick: one pulse every TICK_DIV clocks, or every clock when stuck
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tickCnt++;
      if (tickStuck)                                    bus.s_tick = 1'b1;
      else if (tickEnable && (tickCnt % TICK_DIV == 0)) bus.s_tick = 1'b1;
      else                                              bus.s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      runLen++;
      if (runLen == 1) begin
        doneCount++;
        lastDoneCycle = cycleNum;
        busyAtDone    = bus.busy;
      end
      if (runLen > maxRun) maxRun = runLen;
    end else begin
      runLen = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveBit(input logic v);
    bus.rx = v;
    repeat (bitClks) @(negedge clk);
  endtask

  task automatic idleBits(input int nBits);
    bus.rx = 1'b1;
    repeat (nBits * bitClks) @(negedge clk);
  endtask

  // Called on a negedge; drives start, 8 data bits LSB first, then the stop bit
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    startCycle = cycleNum;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
    bus.rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.rx  = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", 32'(bus.rx_dout), 32'h00);
    checkOutput("rst_ferr", 32'(bus.frame_err), 32'h0);
    checkOutput("rst_done", 32'(bus.rx_done_tick), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;

    $display("[TB] clean 0xA5 with s_tick stuck high");
    tickStuck = 1'b1;
    bitClks   = 16;
    idleBits(2);
    applyStimulus(8'hA5, 1'b1);
    idleBits(1);
    checkOutput("a5_latency", 32'(lastDoneCycle - startCycle), 32'd155);
    checkOutput("a5_dout", 32'(bus.rx_dout), 32'hA5);
    checkOutput("a5_ferr", 32'(bus.frame_err), 32'h0);
    checkOutput("a5_busy_at_done", 32'(busyAtDone), 32'h0);
    checkOutput("a5_count", 32'(doneCount), 32'd1);

    $display("[TB] back-to-back frames");
    tickStuck = 1'b0;
    bitClks   = 16 * TICK_DIV;
    idleBits(2);
    baseCount = doneCount;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b2bVec[i], 1'b1);
      checkOutput($sformatf("b2b_dout%0d", i), 32'(bus.rx_dout), 32'(b2bVec[i]));
      checkOutput($sformatf("b2b_ferr%0d", i), 32'(bus.frame_err), 32'h0);
    end
    idleBits(1);
    checkOutput("b2b_count", 32'(doneCount - baseCount), 32'd3);

    $display("[TB] glitch rejection");
    baseCount = doneCount;
    bus.rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    idleBits(2);
    checkOutput("glitch_count", 32'(doneCount - baseCount), 32'd0);
    checkOutput("glitch_dout", 32'(bus.rx_dout), 32'h55);
    checkOutput("glitch_busy", 32'(bus.busy), 32'h0);

    $display("[TB] s_tick held low");
    tickEnable = 1'b0;
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("stall_busy", 32'(bus.busy), 32'h1);
    checkOutput("stall_count", 32'(doneCount - baseCount), 32'd0);
    tickEnable = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("stall_resume_busy", 32'(bus.busy), 32'h0);

    $display("[TB] framing error then clean frame");
    idleBits(1);
    baseCount = doneCount;
    applyStimulus(8'h3C, 1'b0);
    idleBits(2);
    checkOutput("ferr_dout", 32'(bus.rx_dout), 32'h3C);
    checkOutput("ferr_flag", 32'(bus.frame_err), 32'h1);
    applyStimulus(8'h12, 1'b1);
    idleBits(1);
    checkOutput("clear_dout", 32'(bus.rx_dout), 32'h12);
    checkOutput("clear_ferr", 32'(bus.frame_err), 32'h0);
    applyStimulus(8'hC3, 1'b0);
    idleBits(2);
    checkOutput("ferr2_dout", 32'(bus.rx_dout), 32'hC3);
    checkOutput("ferr_count", 32'(doneCount - baseCount), 32'd3);

    $display("[TB] reset during data bit 4 of 0x81");
    baseCount = doneCount;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b0);
    bus.rx = 1'b0;
    repeat (bitClks / 2) @(negedge clk);
    checkOutput("mid_busy", 32'(bus.busy), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_dout", 32'(bus.rx_dout), 32'h00);
    checkOutput("async_ferr", 32'(bus.frame_err), 32'h0);
    checkOutput("async_busy", 32'(bus.busy), 32'h0);
    checkOutput("async_done", 32'(bus.rx_done_tick), 32'h0);
    bus.rx = 1'b1;
    repeat (2 * bitClks) @(negedge clk);
    reset_n = 1'b1;
    idleBits(2);
    checkOutput("rst_no_pulse", 32'(doneCount - baseCount), 32'd0);
    applyStimulus(8'h7E, 1'b1);
    idleBits(1);
    checkOutput("after_rst_dout", 32'(bus.rx_dout), 32'h7E);
    checkOutput("after_rst_ferr", 32'(bus.frame_err), 32'h0);
    checkOutput("after_rst_count", 32'(doneCount - baseCount), 32'd1);

    $display("[TB] break condition");
    baseCount = doneCount;
    bus.rx = 1'b0;
    repeat (30 * bitClks) @(negedge clk);
    checkOutput("break_count", 32'(doneCount - baseCount), 32'd1);
    checkOutput("break_dout", 32'(bus.rx_dout), 32'h00);
    checkOutput("break_ferr", 32'(bus.frame_err), 32'h1);
    checkOutput("break_busy", 32'(bus.busy), 32'h0);
    idleBits(3);
    checkOutput("break_release_count", 32'(doneCount - baseCount), 32'd1);

    checkOutput("done_width", 32'(maxRun), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
